// File: rtl/snake_grid_renderer.sv
// ---------------------------------------------------------------------------
// snake_grid_renderer
//
// Per-pixel renderer for the snake game. It sits between the VGA sync
// generator and the VGA pins. The pixel stream is mapped onto a
// GRID_W x GRID_H cell grid by counting pixels and lines rather than
// dividing. One colour is produced per pixel, with two cycles of latency.
//
// Ports:
//   clock                  pixel clock
//   reset                  synchronous, active-high
//   in_display_area        active-video flag from the sync generator
//   frame_start            one-cycle pulse in vertical blanking
//   h_sync_in, v_sync_in   syncs from the generator
//   game_status            00 PAUSED, 01 PLAYING, 10 DIE_FLASHING,
//                          11 INITIALIZING
//   snake_color            3-bit snake colour
//   snake_x/y_flat         packed piece coordinates, piece 0 is the head
//   snake_piece_is_display per-piece enable
//   apple_x/y_flat         packed apple coordinates
//   apple_bonus            per-apple bonus flag
//   wall_x/y_flat          packed wall coordinates
//   h_sync, v_sync         syncs delayed two cycles, aligned with vga
//   vga                    12-bit pixel colour
// ---------------------------------------------------------------------------
module snake_grid_renderer #(
    parameter int COORD_W      = 6,
    parameter int GRID_W       = 49,
    parameter int GRID_H       = 27,
    parameter int CELL_W       = 21,
    parameter int CELL_H       = 28,
    parameter int SNAKE_LEN    = 32,
    parameter int APPLE_N      = 5,
    parameter int WALL_N       = 8,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           in_display_area,
    input  logic                           frame_start,
    input  logic                           h_sync_in,
    input  logic                           v_sync_in,
    input  logic [1:0]                     game_status,
    input  logic [2:0]                     snake_color,
    input  logic [SNAKE_LEN*COORD_W-1:0]   snake_x_flat,
    input  logic [SNAKE_LEN*COORD_W-1:0]   snake_y_flat,
    input  logic [SNAKE_LEN-1:0]           snake_piece_is_display,
    input  logic [APPLE_N*COORD_W-1:0]     apple_x_flat,
    input  logic [APPLE_N*COORD_W-1:0]     apple_y_flat,
    input  logic [APPLE_N-1:0]             apple_bonus,
    input  logic [WALL_N*COORD_W-1:0]      wall_x_flat,
    input  logic [WALL_N*COORD_W-1:0]      wall_y_flat,
    output logic                           h_sync,
    output logic                           v_sync,
    output logic [11:0]                    vga
);

    localparam int SUB_X_W = $clog2(CELL_W + 1);
    localparam int SUB_Y_W = $clog2(CELL_H + 1);
    localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [1:0] {
        PAUSED       = 2'b00,
        PLAYING      = 2'b01,
        DIE_FLASHING = 2'b10,
        INITIALIZING = 2'b11
    } status_t;

    status_t status;
    assign status = status_t'(game_status);

    logic [SUB_X_W-1:0] sub_x;
    logic [SUB_Y_W-1:0] sub_y;
    logic [COORD_W-1:0] cell_x;
    logic [COORD_W-1:0] cell_y;

    logic               display_d1;
    logic               hs_d1;
    logic               vs_d1;
    logic [COORD_W-1:0] cell_x_s1;
    logic [COORD_W-1:0] cell_y_s1;

    logic [BLINK_W-1:0] frame_cnt;
    logic               blink_phase;

    logic               line_end;
    assign line_end = display_d1 && !in_display_area;

    // The counters describe the pixel presented in the current cycle. The
    // x counters are zero whenever video is inactive, so each line starts
    // at cell 0. Saturation keeps pixels past the grid on the last
    // (border) column/row instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            sub_x  <= '0;
            cell_x <= '0;
        end else if (!in_display_area) begin
            sub_x  <= '0;
            cell_x <= '0;
        end else if (sub_x == SUB_X_W'(CELL_W - 1)) begin
            sub_x <= '0;
            if (cell_x != COORD_W'(GRID_W - 1))
                cell_x <= cell_x + 1'b1;
        end else begin
            sub_x <= sub_x + 1'b1;
        end
    end

    // Vertical counters advance on the falling edge of active video.
    // frame_start has priority so a frame always begins on row 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            sub_y  <= '0;
            cell_y <= '0;
        end else if (frame_start) begin
            sub_y  <= '0;
            cell_y <= '0;
        end else if (line_end) begin
            if (sub_y == SUB_Y_W'(CELL_H - 1)) begin
                sub_y <= '0;
                if (cell_y != COORD_W'(GRID_H - 1))
                    cell_y <= cell_y + 1'b1;
            end else begin
                sub_y <= sub_y + 1'b1;
            end
        end
    end

    // Stage 1 register: freezes the cell position of this cycle's pixel
    // together with its video flag and syncs so that they stay aligned.
    always_ff @(posedge clock) begin
        if (reset) begin
            display_d1 <= 1'b0;
            hs_d1      <= 1'b0;
            vs_d1      <= 1'b0;
            cell_x_s1  <= '0;
            cell_y_s1  <= '0;
        end else begin
            display_d1 <= in_display_area;
            hs_d1      <= h_sync_in;
            vs_d1      <= v_sync_in;
            cell_x_s1  <= cell_x;
            cell_y_s1  <= cell_y;
        end
    end

    // Death blink: count frames while flashing, toggle the dark phase
    // every BLINK_FRAMES frames, and drop straight back to the lit phase
    // as soon as the game leaves the flashing state.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (status != DIE_FLASHING) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    logic        is_border;
    logic        wall_hit;
    logic        apple_hit;
    logic        apple_is_bonus;
    logic        head_hit;
    logic        body_hit;
    logic [11:0] head_color;
    logic [11:0] body_color;
    logic [11:0] pixel_color;

    // Object matching against the stage-1 cell. When several apples share
    // a cell the lowest-index apple decides the bonus colour.
    always_comb begin
        wall_hit       = 1'b0;
        apple_hit      = 1'b0;
        apple_is_bonus = 1'b0;
        body_hit       = 1'b0;
        head_color     = '0;
        body_color     = '0;

        is_border = (cell_x_s1 == '0) || (cell_x_s1 == COORD_W'(GRID_W - 1)) ||
                    (cell_y_s1 == '0) || (cell_y_s1 == COORD_W'(GRID_H - 1));

        for (int k = 0; k < WALL_N; k++) begin
            if (wall_x_flat[k*COORD_W +: COORD_W] == cell_x_s1 &&
                wall_y_flat[k*COORD_W +: COORD_W] == cell_y_s1)
                wall_hit = 1'b1;
        end

        for (int k = 0; k < APPLE_N; k++) begin
            if (!apple_hit &&
                apple_x_flat[k*COORD_W +: COORD_W] == cell_x_s1 &&
                apple_y_flat[k*COORD_W +: COORD_W] == cell_y_s1) begin
                apple_hit      = 1'b1;
                apple_is_bonus = apple_bonus[k];
            end
        end

        head_hit = snake_piece_is_display[0] &&
                   snake_x_flat[COORD_W-1:0] == cell_x_s1 &&
                   snake_y_flat[COORD_W-1:0] == cell_y_s1;

        for (int k = 1; k < SNAKE_LEN; k++) begin
            if (snake_piece_is_display[k] &&
                snake_x_flat[k*COORD_W +: COORD_W] == cell_x_s1 &&
                snake_y_flat[k*COORD_W +: COORD_W] == cell_y_s1)
                body_hit = 1'b1;
        end

        // Each colour bit fills a whole nibble; the head is brightened and
        // the body dimmed so the two are always distinguishable.
        for (int n = 0; n < 3; n++) begin
            head_color[n*4 +: 4] = {4{snake_color[n]}} | 4'b0100;
            body_color[n*4 +: 4] = {4{snake_color[n]}} & 4'b0111;
        end
    end

    // Colour priority, highest first.
    always_comb begin
        pixel_color = 12'h000;
        if (!display_d1)
            pixel_color = 12'h000;
        else if (status == DIE_FLASHING && blink_phase)
            pixel_color = 12'h000;
        else if (is_border)
            pixel_color = (status == PLAYING || status == DIE_FLASHING) ? 12'hFFF : 12'h777;
        else if (wall_hit)
            pixel_color = 12'hFFF;
        else if (apple_hit)
            pixel_color = apple_is_bonus ? 12'h0FF : 12'h00F;
        else if (head_hit)
            pixel_color = head_color;
        else if (body_hit)
            pixel_color = body_color;
    end

    // Stage 2 register: colour and syncs leave together.
    always_ff @(posedge clock) begin
        if (reset) begin
            vga    <= 12'h000;
            h_sync <= 1'b0;
            v_sync <= 1'b0;
        end else begin
            vga    <= pixel_color;
            h_sync <= hs_d1;
            v_sync <= vs_d1;
        end
    end

endmodule

// File: tb/tb_snake_grid_renderer.sv
// ---------------------------------------------------------------------------
// tb_snake_grid_renderer
//
// Drives whole video frames with randomised objects and syncs into a
// reduced-size renderer and compares every output cycle with a reference
// computed from pixel/line positions by division and simple object lookups.
// ---------------------------------------------------------------------------
module tb_snake_grid_renderer;

    localparam int COORD_W      = 6;
    localparam int GRID_W       = 24;
    localparam int GRID_H       = 22;
    localparam int CELL_W       = 2;
    localparam int CELL_H       = 2;
    localparam int SNAKE_LEN    = 32;
    localparam int APPLE_N      = 5;
    localparam int WALL_N       = 8;
    localparam int BLINK_FRAMES = 2;

    // Active area runs a few pixels/lines past the grid to exercise saturation.
    localparam int H_ACTIVE = GRID_W * CELL_W + 4;
    localparam int H_BLANK  = 10;
    localparam int V_ACTIVE = GRID_H * CELL_H + 2;
    localparam int V_BLANK  = 3;

    localparam logic [1:0] ST_PAUSED  = 2'b00;
    localparam logic [1:0] ST_PLAYING = 2'b01;
    localparam logic [1:0] ST_DIE     = 2'b10;
    localparam logic [1:0] ST_INIT    = 2'b11;

    logic                         clock = 1'b0;
    logic                         reset = 1'b1;
    logic                         in_display_area = 1'b0;
    logic                         frame_start = 1'b0;
    logic                         h_sync_in = 1'b0;
    logic                         v_sync_in = 1'b0;
    logic [1:0]                   game_status = ST_PLAYING;
    logic [2:0]                   snake_color = 3'b000;
    logic [SNAKE_LEN*COORD_W-1:0] snake_x_flat = '0;
    logic [SNAKE_LEN*COORD_W-1:0] snake_y_flat = '0;
    logic [SNAKE_LEN-1:0]         snake_piece_is_display = '0;
    logic [APPLE_N*COORD_W-1:0]   apple_x_flat = '0;
    logic [APPLE_N*COORD_W-1:0]   apple_y_flat = '0;
    logic [APPLE_N-1:0]           apple_bonus = '0;
    logic [WALL_N*COORD_W-1:0]    wall_x_flat = '0;
    logic [WALL_N*COORD_W-1:0]    wall_y_flat = '0;
    logic                         h_sync;
    logic                         v_sync;
    logic [11:0]                  vga;

    snake_grid_renderer #(
        .COORD_W(COORD_W), .GRID_W(GRID_W), .GRID_H(GRID_H),
        .CELL_W(CELL_W), .CELL_H(CELL_H), .SNAKE_LEN(SNAKE_LEN),
        .APPLE_N(APPLE_N), .WALL_N(WALL_N), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_display_area(in_display_area),
        .frame_start(frame_start),
        .h_sync_in(h_sync_in),
        .v_sync_in(v_sync_in),
        .game_status(game_status),
        .snake_color(snake_color),
        .snake_x_flat(snake_x_flat),
        .snake_y_flat(snake_y_flat),
        .snake_piece_is_display(snake_piece_is_display),
        .apple_x_flat(apple_x_flat),
        .apple_y_flat(apple_y_flat),
        .apple_bonus(apple_bonus),
        .wall_x_flat(wall_x_flat),
        .wall_y_flat(wall_y_flat),
        .h_sync(h_sync),
        .v_sync(v_sync),
        .vga(vga)
    );

    always #5 clock = ~clock;

    // Reference object state
    int   sx [SNAKE_LEN];
    int   sy [SNAKE_LEN];
    bit   sen [SNAKE_LEN];
    int   ax [APPLE_N];
    int   ay [APPLE_N];
    bit   abonus [APPLE_N];
    int   wx [WALL_N];
    int   wy [WALL_N];

    int   checks = 0;
    int   errors = 0;
    int   die_frames = 0;
    bit   vga_armed = 1'b0;
    bit   rst_seen = 1'b1;

    typedef struct {
        logic [11:0] color;
        logic        hs;
        logic        vs;
        bit          check_vga;
    } exp_t;

    exp_t pipe[$];

    task automatic checkOutput(input string tag, input logic [11:0] observed,
                               input logic [11:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [11:0] model_pixel(input int px, input int ly);
        int          cx;
        int          cy;
        logic [3:0]  nib;
        logic [11:0] result;
        cx = px / CELL_W;
        if (cx > GRID_W - 1) cx = GRID_W - 1;
        cy = ly / CELL_H;
        if (cy > GRID_H - 1) cy = GRID_H - 1;

        if (game_status == ST_DIE && ((die_frames / BLINK_FRAMES) % 2) == 1)
            return 12'h000;
        if (cx == 0 || cx == GRID_W - 1 || cy == 0 || cy == GRID_H - 1)
            return (game_status == ST_PLAYING || game_status == ST_DIE) ? 12'hFFF : 12'h777;
        for (int k = 0; k < WALL_N; k++)
            if (wx[k] == cx && wy[k] == cy) return 12'hFFF;
        for (int k = 0; k < APPLE_N; k++)
            if (ax[k] == cx && ay[k] == cy) return abonus[k] ? 12'h0FF : 12'h00F;
        result = 12'h000;
        if (sen[0] && sx[0] == cx && sy[0] == cy) begin
            for (int n = 0; n < 3; n++) begin
                nib = snake_color[n] ? 4'hF : 4'h0;
                nib[2] = 1'b1;
                result[n*4 +: 4] = nib;
            end
            return result;
        end
        for (int k = 1; k < SNAKE_LEN; k++) begin
            if (sen[k] && sx[k] == cx && sy[k] == cy) begin
                for (int n = 0; n < 3; n++) begin
                    nib = snake_color[n] ? 4'hF : 4'h0;
                    nib[3] = 1'b0;
                    result[n*4 +: 4] = nib;
                end
                return result;
            end
        end
        return 12'h000;
    endfunction

    task automatic pack_objects();
        for (int k = 0; k < SNAKE_LEN; k++) begin
            snake_x_flat[k*COORD_W +: COORD_W] = COORD_W'(sx[k]);
            snake_y_flat[k*COORD_W +: COORD_W] = COORD_W'(sy[k]);
            snake_piece_is_display[k] = sen[k];
        end
        for (int k = 0; k < APPLE_N; k++) begin
            apple_x_flat[k*COORD_W +: COORD_W] = COORD_W'(ax[k]);
            apple_y_flat[k*COORD_W +: COORD_W] = COORD_W'(ay[k]);
            apple_bonus[k] = abonus[k];
        end
        for (int k = 0; k < WALL_N; k++) begin
            wall_x_flat[k*COORD_W +: COORD_W] = COORD_W'(wx[k]);
            wall_y_flat[k*COORD_W +: COORD_W] = COORD_W'(wy[k]);
        end
    endtask

    // Coordinates range slightly past the grid so off-grid objects occur.
    task automatic randomize_objects();
        for (int k = 0; k < SNAKE_LEN; k++) begin
            sx[k]  = $urandom_range(0, GRID_W + 3);
            sy[k]  = $urandom_range(0, GRID_H + 3);
            sen[k] = 1'($urandom_range(0, 1));
        end
        for (int k = 0; k < APPLE_N; k++) begin
            ax[k]     = $urandom_range(0, GRID_W + 3);
            ay[k]     = $urandom_range(0, GRID_H + 3);
            abonus[k] = 1'($urandom_range(0, 1));
        end
        for (int k = 0; k < WALL_N; k++) begin
            wx[k] = $urandom_range(0, GRID_W + 3);
            wy[k] = $urandom_range(0, GRID_H + 3);
        end
        snake_color = 3'($urandom_range(0, 7));
    endtask

    task automatic set_status(input logic [1:0] st);
        game_status = st;
        if (st != ST_DIE) die_frames = 0;
    endtask

    // One clock cycle: check the outputs due now, then drive the next input.
    task automatic applyStimulus(input logic disp, input logic fs, input int px,
                                 input int ly, input logic rst);
        exp_t e;
        exp_t old;
        @(posedge clock);
        #1;
        if (rst_seen) begin
            checkOutput("rst_vga", vga, 12'h000);
            checkOutput("rst_h_sync", {11'b0, h_sync}, 12'h000);
            checkOutput("rst_v_sync", {11'b0, v_sync}, 12'h000);
            pipe.delete();
            vga_armed  = 1'b0;
            die_frames = 0;
        end else if (pipe.size() >= 2) begin
            old = pipe.pop_front();
            checkOutput("h_sync", {11'b0, h_sync}, {11'b0, old.hs});
            checkOutput("v_sync", {11'b0, v_sync}, {11'b0, old.vs});
            if (old.check_vga) checkOutput("vga", vga, old.color);
        end

        reset           = rst;
        rst_seen        = rst;
        in_display_area = disp;
        frame_start     = fs;
        h_sync_in       = 1'($urandom_range(0, 1));
        v_sync_in       = 1'($urandom_range(0, 1));
        if (fs && !rst) begin
            vga_armed = 1'b1;
            if (game_status == ST_DIE) die_frames++;
        end
        e.hs        = h_sync_in;
        e.vs        = v_sync_in;
        e.check_vga = vga_armed;
        e.color     = disp ? model_pixel(px, ly) : 12'h000;
        pipe.push_back(e);
    endtask

    task automatic run_frame(input int rst_line);
        for (int l = 0; l < V_BLANK; l++)
            for (int p = 0; p < H_ACTIVE + H_BLANK; p++)
                applyStimulus(1'b0, (l == 1 && p == 5), 0, 0, 1'b0);
        for (int l = 0; l < V_ACTIVE; l++) begin
            for (int p = 0; p < H_ACTIVE; p++)
                applyStimulus(1'b1, 1'b0, p, l, (l == rst_line && p >= 20 && p < 23));
            for (int p = 0; p < H_BLANK; p++)
                applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
        end
    endtask

    initial begin
        randomize_objects();
        pack_objects();
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);

        // Wall and apple on the same cell: wall wins.
        randomize_objects();
        wx[0] = 5; wy[0] = 3; ax[0] = 5; ay[0] = 3;
        set_status(ST_PLAYING);
        pack_objects();
        run_frame(-1);

        // Apple alone on the neighbouring cell.
        ax[0] = 6; ay[0] = 3;
        pack_objects();
        run_frame(-1);

        // Head, lit body piece and disabled body piece.
        randomize_objects();
        snake_color = 3'b101;
        sx[0] = 10; sy[0] = 10; sen[0] = 1'b1;
        sx[1] = 11; sy[1] = 10; sen[1] = 1'b1;
        sx[2] = 12; sy[2] = 10; sen[2] = 1'b0;
        pack_objects();
        run_frame(-1);

        // Paused border and a bonus apple.
        randomize_objects();
        ax[3] = 20; ay[3] = 20; abonus[3] = 1'b1;
        set_status(ST_PAUSED);
        pack_objects();
        run_frame(-1);

        randomize_objects();
        set_status(ST_INIT);
        pack_objects();
        run_frame(-1);

        // Flashing long enough to reach the dark phase, then leave it.
        set_status(ST_DIE);
        for (int f = 0; f < 3; f++) begin
            randomize_objects();
            pack_objects();
            run_frame(-1);
        end
        randomize_objects();
        set_status(ST_PLAYING);
        pack_objects();
        run_frame(-1);

        set_status(ST_DIE);
        for (int f = 0; f < 5; f++) begin
            randomize_objects();
            pack_objects();
            run_frame(-1);
        end

        // Reset in the middle of active video, then a clean frame.
        randomize_objects();
        set_status(ST_PLAYING);
        pack_objects();
        run_frame(7);
        randomize_objects();
        pack_objects();
        run_frame(-1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
